psm_multi_channel: RTL and testbench

PSM_MULTI_CHANNEL -- requirements
Module: psm_multi_channel

---
 rtl/psm_multi_channel.sv | 202 ++++++++++++++++++++
 tb/tb_psm_multi_channel.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : psm_multi_channel
//  Description : Multi-channel pulse-skip-modulation regulator. Each channel
//                has a hysteretic IDLE/REGULATE/CLAMP_HOLD controller that
//                updates on its sample strobe, plus a free-running PWM
//                counter. Pending channels are granted by a round-robin
//                arbiter that serves emergency channels first and limits the
//                number of simultaneous requests to MAX_ON.
//  Revision    : 1.0 - initial release
// ============================================================================
module psm_multi_channel #(
  parameter int                NCH        = 2,
  parameter int                ADC_W      = 12,
  parameter int                RESOLUTION = 9,
  parameter int                DUTY       = 225,
  parameter logic [ADC_W-1:0]  V_REF      = ADC_W'(3150),
  parameter logic [ADC_W-1:0]  BASE_LOW   = ADC_W'(3100),
  parameter logic [ADC_W-1:0]  BASE_HIGH  = ADC_W'(3200),
  parameter int                EMERGENCY  = 400,
  parameter int                OVER_LIMIT = 180,
  parameter logic [ADC_W-1:0]  V_MAX      = ADC_W'(3245),
  parameter logic [3:0]        HOLD       = 4'd6,
  parameter int                MAX_ON     = NCH
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic [NCH*ADC_W-1:0]       volt_in,
  input  logic [NCH-1:0]             drdy_in,
  output logic [NCH-1:0]             psm_request,
  output logic [NCH*(ADC_W+1)-1:0]   error_out,
  output logic [NCH-1:0]             emergency,
  output logic [NCH-1:0]             clamp_active
);

  localparam int RR_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_reg  = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  localparam logic signed [ADC_W:0] c_emg_thr  = (ADC_W+1)'(EMERGENCY);
  localparam logic signed [ADC_W:0] c_over_thr = (ADC_W+1)'(-OVER_LIMIT);
  localparam logic [RESOLUTION:0]   c_duty     = (RESOLUTION+1)'(DUTY);
  localparam logic [RR_W:0]         c_nch      = (RR_W+1)'(NCH);

  // Registered per-channel pending flags; emergency-pending is captured with
  // pend so that priority is decided on the same sample that raised pend.
  logic [NCH-1:0]  w_pend;
  logic [NCH-1:0]  w_emg_pend;
  logic [NCH-1:0]  w_grant;
  logic            w_any;
  logic [RR_W-1:0] w_last;
  logic [RR_W-1:0] w_rr_next;
  logic [RR_W-1:0] r_rr;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [ADC_W-1:0]        w_volt;
    logic signed [ADC_W:0]   w_err;
    logic signed [ADC_W+1:0] w_err_x;
    logic signed [ADC_W+1:0] w_volt_x;
    logic signed [ADC_W+1:0] w_low;
    logic signed [ADC_W+1:0] w_high;
    logic                    w_clamp;
    logic                    w_emg;
    logic                    w_pwm;
    logic                    w_pend_next;
    logic                    w_clamp_act;
    logic [RESOLUTION-1:0]   r_cnt;
    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [3:0]              r_timer;
    logic [3:0]              w_timer_next;
    logic                    r_pend;
    logic                    r_emg_pend;

    assign w_volt   = volt_in[c*ADC_W +: ADC_W];
    assign w_err    = $signed({1'b0, V_REF}) - $signed({1'b0, w_volt});
    assign w_err_x  = {w_err[ADC_W], w_err};
    assign w_volt_x = $signed({2'b00, w_volt});
    // Thresholds widened by one bit so large errors cannot wrap the compare.
    assign w_low    = $signed({2'b00, BASE_LOW})  - (w_err_x >>> 1);
    assign w_high   = $signed({2'b00, BASE_HIGH}) - (w_err_x >>> 2);
    assign w_clamp  = (w_err < c_over_thr) || (w_volt > V_MAX);
    assign w_emg    = (w_err > c_emg_thr);
    assign w_pwm    = ({1'b0, r_cnt} < c_duty);

    assign error_out[c*(ADC_W+1) +: ADC_W+1] = w_err;
    assign emergency[c]    = w_emg;
    assign clamp_active[c] = w_clamp_act;
    assign w_pend[c]       = r_pend;
    assign w_emg_pend[c]   = r_emg_pend;

    // Free-running PWM counter, restarted while the channel is clamped.
    always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
        r_cnt <= '0;
      end else if (w_clamp) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + RESOLUTION'(1);
      end
    end

    // Controller state register, advanced only on this channel's strobe.
    always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
        r_state    <= c_st_idle;
        r_timer    <= '0;
        r_pend     <= 1'b0;
        r_emg_pend <= 1'b0;
      end else if (drdy_in[c]) begin
        r_state    <= w_state_next;
        r_timer    <= w_timer_next;
        r_pend     <= w_pend_next;
        r_emg_pend <= w_pend_next && w_emg;
      end
    end

    // Next-state logic; a clamp condition overrides every other transition.
    always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer;
      if (w_clamp) begin
        w_state_next = c_st_hold;
        w_timer_next = HOLD;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (w_volt_x < w_low) w_state_next = c_st_reg;
          end
          c_st_reg: begin
            if (w_volt_x > w_high) w_state_next = c_st_idle;
          end
          c_st_hold: begin
            if (r_timer > 4'd1) begin
              w_timer_next = r_timer - 4'd1;
            end else begin
              w_state_next = c_st_idle;
              w_timer_next = '0;
            end
          end
          default: begin
            w_state_next = c_st_idle;
            w_timer_next = '0;
          end
        endcase
      end
    end

    // Outputs decoded from state: clamp flag and the pend value to capture.
    always_comb begin
      w_clamp_act = (r_state == c_st_hold);
      w_pend_next = !w_clamp && (w_state_next != c_st_hold) &&
                    (((w_state_next == c_st_reg) && w_pwm) || w_emg);
    end
  end

  // Two-pass round-robin grant: emergency-pending first, then the rest.
  always_comb begin
    logic [RR_W:0] idx;
    logic          sel;
    int            n_on;
    idx     = '0;
    sel     = 1'b0;
    n_on    = 0;
    w_grant = '0;
    w_any   = 1'b0;
    w_last  = r_rr;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NCH; i++) begin
        idx = {1'b0, r_rr} + (RR_W+1)'(i);
        if (idx >= c_nch) idx = idx - c_nch;
        if (pass == 0) begin
          sel = w_emg_pend[idx[RR_W-1:0]];
        end else begin
          sel = w_pend[idx[RR_W-1:0]] && !w_emg_pend[idx[RR_W-1:0]];
        end
        if (sel && (n_on < MAX_ON)) begin
          w_grant[idx[RR_W-1:0]] = 1'b1;
          n_on   = n_on + 1;
          w_last = idx[RR_W-1:0];
          w_any  = 1'b1;
        end
      end
    end
    w_rr_next = (w_last == RR_W'(NCH - 1)) ? '0 : w_last + RR_W'(1);
  end

  // Request register and round-robin pointer.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      psm_request <= '0;
      r_rr        <= '0;
    end else begin
      psm_request <= w_grant;
      if (w_any) r_rr <= w_rr_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psm_multi_channel
//  Description : Self-checking bench for psm_multi_channel. Two instances
//                share stimulus: one with MAX_ON=NCH, one with MAX_ON=1.
//                A behavioural model predicts requests and clamp flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psm_multi_channel;
  localparam int NCH   = 2;
  localparam int ADC_W = 12;
  localparam int EW    = ADC_W + 1;
  localparam int M_IDLE = 0;
  localparam int M_REG  = 1;
  localparam int M_HOLD = 2;

  logic                 clk = 1'b0;
  logic                 reset_in;
  logic [NCH*ADC_W-1:0] volt_in;
  logic [NCH-1:0]       drdy_in;
  logic [NCH-1:0]       psm_a, emg_a, clamp_a;
  logic [NCH-1:0]       psm_b, emg_b, clamp_b;
  logic [NCH*EW-1:0]    err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  int             vin[NCH];
  logic [NCH-1:0] dset;

  // Reference model state, index 0 = unlimited instance, 1 = MAX_ON=1.
  int             st[2][NCH];
  int             tmr[2][NCH];
  int             cnt[2][NCH];
  int             rr[2];
  bit             pend[2][NCH];
  bit             epend[2][NCH];
  logic [NCH-1:0] mpsm[2];

  always #5 clk = ~clk;

  psm_multi_channel #(.NCH(NCH)) dut_a (
    .clk(clk), .reset_in(reset_in), .volt_in(volt_in), .drdy_in(drdy_in),
    .psm_request(psm_a), .error_out(err_a), .emergency(emg_a),
    .clamp_active(clamp_a)
  );

  psm_multi_channel #(.NCH(NCH), .MAX_ON(1)) dut_b (
    .clk(clk), .reset_in(reset_in), .volt_in(volt_in), .drdy_in(drdy_in),
    .psm_request(psm_b), .error_out(err_b), .emergency(emg_b),
    .clamp_active(clamp_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      rr[m] = 0;
      mpsm[m] = '0;
      for (int c = 0; c < NCH; c++) begin
        st[m][c] = M_IDLE; tmr[m][c] = 0; cnt[m][c] = 0;
        pend[m][c] = 1'b0; epend[m][c] = 1'b0;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      int maxon;
      int ng;
      int order[$];
      logic [NCH-1:0] g;
      maxon = (m == 0) ? NCH : 1;
      g = '0;
      for (int k = 0; k < NCH; k++)
        if (epend[m][(rr[m] + k) % NCH]) order.push_back((rr[m] + k) % NCH);
      for (int k = 0; k < NCH; k++)
        if (pend[m][(rr[m] + k) % NCH] && !epend[m][(rr[m] + k) % NCH])
          order.push_back((rr[m] + k) % NCH);
      ng = (order.size() < maxon) ? order.size() : maxon;
      for (int k = 0; k < ng; k++) g[order[k]] = 1'b1;
      if (ng > 0) rr[m] = (order[ng-1] + 1) % NCH;
      mpsm[m] = g;
      for (int c = 0; c < NCH; c++) begin
        int v, err, ns;
        bit emg, clp, pwm;
        v   = vin[c];
        err = 3150 - v;
        emg = (err > 400);
        clp = (err < -180) || (v > 3245);
        pwm = (cnt[m][c] < 225);
        if (dset[c]) begin
          ns = st[m][c];
          if (clp) begin
            ns = M_HOLD; tmr[m][c] = 6;
          end else if (st[m][c] == M_IDLE && v < 3100 - (err >>> 1)) begin
            ns = M_REG;
          end else if (st[m][c] == M_REG && v > 3200 - (err >>> 2)) begin
            ns = M_IDLE;
          end else if (st[m][c] == M_HOLD) begin
            if (tmr[m][c] > 1) tmr[m][c] = tmr[m][c] - 1;
            else begin ns = M_IDLE; tmr[m][c] = 0; end
          end
          pend[m][c]  = !clp && (ns != M_HOLD) && ((ns == M_REG && pwm) || emg);
          epend[m][c] = pend[m][c] && emg;
          st[m][c]    = ns;
        end
        cnt[m][c] = clp ? 0 : (cnt[m][c] + 1) % 512;
      end
    end
  endfunction

  // One clock: apply inputs at the falling edge, check the combinational
  // outputs, step the model, then check registered outputs after the edge.
  task automatic tick();
    logic [EW-1:0]  ee;
    logic [NCH-1:0] ec0, ec1;
    @(negedge clk);
    reset_in = 1'b0;
    for (int c = 0; c < NCH; c++) volt_in[c*ADC_W +: ADC_W] = ADC_W'(vin[c]);
    drdy_in = dset;
    #1;
    for (int c = 0; c < NCH; c++) begin
      ee = EW'(3150 - vin[c]);
      check("error_out", 64'(err_a[c*EW +: EW]), 64'(ee));
      check("emergency_a", 64'(emg_a[c]), 64'((3150 - vin[c]) > 400));
      check("emergency_b", 64'(emg_b[c]), 64'((3150 - vin[c]) > 400));
    end
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      ec0[c] = (st[0][c] == M_HOLD);
      ec1[c] = (st[1][c] == M_HOLD);
    end
    check("psm_request_a", 64'(psm_a), 64'(mpsm[0]));
    check("psm_request_b", 64'(psm_b), 64'(mpsm[1]));
    check("clamp_active_a", 64'(clamp_a), 64'(ec0));
    check("clamp_active_b", 64'(clamp_b), 64'(ec1));
  endtask

  initial begin
    int ones;
    logic [NCH-1:0] prev;
    reset_in = 1'b1;
    drdy_in  = '0;
    dset     = '0;
    vin[0] = 3150; vin[1] = 3150;
    volt_in = {12'd3150, 12'd3150};
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_psm_a", 64'(psm_a), 64'(0));
    check("reset_clamp_a", 64'(clamp_a), 64'(0));
    check("reset_psm_b", 64'(psm_b), 64'(0));
    check("reset_clamp_b", 64'(clamp_b), 64'(0));

    // ch0 regulating at 3000: two-clock latency, then 225/512 duty.
    vin[0] = 3000; vin[1] = 3150; dset = 2'b11;
    tick();
    check("latency_t1", 64'(psm_a), 64'(0));
    tick();
    check("latency_t2", 64'(psm_a), 64'(2'b01));
    ones = 0;
    repeat (512) begin
      tick();
      ones += int'(psm_a[0]);
    end
    check("duty_count", 64'(ones), 64'(225));

    // ch1 emergency: continuously requested, and wins over ch0 when MAX_ON=1.
    vin[1] = 2700;
    tick();
    check("emergency_flag", 64'(emg_a[1]), 64'(1));
    tick();
    repeat (40) begin
      tick();
      check("emg_continuous", 64'(psm_a[1]), 64'(1));
      check("emg_priority", 64'(psm_b), 64'(2'b10));
    end

    // Both regulating with MAX_ON=1: grants alternate, never both.
    vin[1] = 3000;
    prev = '0;
    repeat (120) begin
      tick();
      check("never_both", 64'(psm_b == 2'b11), 64'(0));
      if (prev != '0 && psm_b != '0) check("alternate", 64'(psm_b == prev), 64'(0));
      prev = psm_b;
    end

    // Over-voltage on ch0: clamp held for HOLD samples, strobes spaced out.
    vin[0] = 3250; dset = 2'b01;
    tick();
    check("clamp_set", 64'(clamp_a[0]), 64'(1));
    vin[0] = 3150; dset = 2'b00;
    tick();
    check("clamp_no_req", 64'(psm_a[0]), 64'(0));
    for (int s = 1; s <= 6; s++) begin
      dset = 2'b00;
      tick();
      dset = 2'b01;
      tick();
      check("clamp_hold", 64'(clamp_a[0]), 64'(s < 6));
    end

    // Randomised inputs and strobes.
    repeat (2000) begin
      for (int c = 0; c < NCH; c++) vin[c] = int'($urandom_range(2600, 3400));
      dset = NCH'($urandom_range(0, 3));
      tick();
    end

    // Asynchronous reset in the middle of a clock period.
    vin[0] = 3000; vin[1] = 3000; dset = 2'b11;
    repeat (12) tick();
    #2;
    reset_in = 1'b1;
    #1;
    check("async_psm_a", 64'(psm_a), 64'(0));
    check("async_clamp_a", 64'(clamp_a), 64'(0));
    check("async_psm_b", 64'(psm_b), 64'(0));
    check("async_clamp_b", 64'(clamp_b), 64'(0));
    model_reset();
    dset = 2'b00;
    repeat (5) begin
      tick();
      check("no_req_after_reset", 64'(psm_a | psm_b), 64'(0));
    end
    dset = 2'b11;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
